// File: rtl/l1_trigger_scaler_v3.sv
// rtl/l1_trigger_scaler_v3.sv - per-beam L1 trigger qualifier with holdoff and gated rate scaler
// Optional peak-hold registers are built when L1_SCALER_PEAK_EN is defined.
module l1_trigger_scaler_v3 #(
  parameter int NBEAMS       = 2,
  parameter int COUNT_BITS   = 32,
  parameter int PERIOD_BITS  = 48,
  parameter int HOLDOFF_BITS = 8,
  localparam int BEAM_ADR_BITS = (NBEAMS > 1) ? $clog2(NBEAMS) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NBEAMS-1:0]        trig_i,
  input  logic [NBEAMS-1:0]        mask_i,
  input  logic [HOLDOFF_BITS-1:0]  holdoff_i,
  input  logic [PERIOD_BITS-1:0]   period_i,
  input  logic                     continuous_i,
  input  logic                     start_i,
  input  logic                     stop_i,
  output logic [NBEAMS-1:0]        trigger_o,
  output logic                     busy_o,
  output logic                     done_o,
  input  logic                     rd_stb_i,
  input  logic [BEAM_ADR_BITS-1:0] rd_beam_i,
  input  logic                     rd_peak_i,
  input  logic                     peak_clr_i,
  output logic                     rd_ack_o,
  output logic [COUNT_BITS-1:0]    rd_dat_o,
  output logic                     rd_sat_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COUNT,
    S_LATCH
  } state_t;

  localparam logic [COUNT_BITS-1:0] CNT_MAX = '1;

  state_t                  state;
  logic [HOLDOFF_BITS-1:0] hold [NBEAMS];
  logic [NBEAMS-1:0]       q;
  logic [PERIOD_BITS-1:0]  timer;
  logic [PERIOD_BITS-1:0]  last;
  logic [COUNT_BITS-1:0]   acc  [NBEAMS];
  logic [COUNT_BITS-1:0]   snap [NBEAMS];
  logic [NBEAMS-1:0]       sat;
  logic [NBEAMS-1:0]       snap_sat;
  logic                    latch_take;
  logic [COUNT_BITS-1:0]   rd_sel_dat;
  logic                    rd_sel_sat;

  always_comb begin
    q = '0;
    for (int b = 0; b < NBEAMS; b++) begin
      q[b] = trig_i[b] & mask_i[b] & (hold[b] == '0);
    end
  end

  // A zero period behaves as a one-clock gate.
  assign last = (period_i == '0) ? '0 : period_i - PERIOD_BITS'(1);

  assign latch_take = (state == S_LATCH) && !stop_i && !start_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      trigger_o <= '0;
      for (int b = 0; b < NBEAMS; b++) begin
        hold[b] <= '0;
      end
    end else begin
      trigger_o <= q;
      for (int b = 0; b < NBEAMS; b++) begin
        if (q[b]) begin
          hold[b] <= holdoff_i;
        end else if (hold[b] != '0) begin
          hold[b] <= hold[b] - HOLDOFF_BITS'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= S_IDLE;
      timer    <= '0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      sat      <= '0;
      snap_sat <= '0;
      for (int b = 0; b < NBEAMS; b++) begin
        acc[b]  <= '0;
        snap[b] <= '0;
      end
    end else begin
      done_o <= 1'b0;
      if (stop_i) begin
        state  <= S_IDLE;
        busy_o <= 1'b0;
      end else if (start_i) begin
        state  <= S_COUNT;
        busy_o <= 1'b1;
        timer  <= '0;
        sat    <= '0;
        for (int b = 0; b < NBEAMS; b++) begin
          acc[b] <= '0;
        end
      end else begin
        case (state)
          S_COUNT: begin
            timer <= timer + PERIOD_BITS'(1);
            for (int b = 0; b < NBEAMS; b++) begin
              if (q[b]) begin
                if (acc[b] == CNT_MAX) begin
                  sat[b] <= 1'b1;
                end else begin
                  acc[b] <= acc[b] + COUNT_BITS'(1);
                end
              end
            end
            // >= keeps the gate from running away if period_i shrinks below the timer.
            if (timer >= last) begin
              state <= S_LATCH;
            end
          end
          S_LATCH: begin
            // done_o rises together with the new snapshot becoming readable.
            done_o   <= 1'b1;
            snap_sat <= sat;
            for (int b = 0; b < NBEAMS; b++) begin
              snap[b] <= acc[b];
            end
            if (continuous_i) begin
              state <= S_COUNT;
              timer <= '0;
              sat   <= '0;
              for (int b = 0; b < NBEAMS; b++) begin
                acc[b] <= COUNT_BITS'(q[b]);
              end
            end else begin
              state  <= S_IDLE;
              busy_o <= 1'b0;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

`ifdef L1_SCALER_PEAK_EN
  logic [COUNT_BITS-1:0] peak [NBEAMS];

  always_ff @(posedge clk_i) begin
    if (rst_i || peak_clr_i) begin
      for (int b = 0; b < NBEAMS; b++) begin
        peak[b] <= '0;
      end
    end else if (latch_take) begin
      for (int b = 0; b < NBEAMS; b++) begin
        if (acc[b] > peak[b]) begin
          peak[b] <= acc[b];
        end
      end
    end
  end

  always_comb begin
    rd_sel_dat = '0;
    rd_sel_sat = 1'b0;
    for (int b = 0; b < NBEAMS; b++) begin
      if (int'(rd_beam_i) == b) begin
        rd_sel_dat = rd_peak_i ? peak[b] : snap[b];
        rd_sel_sat = rd_peak_i ? 1'b0 : snap_sat[b];
      end
    end
  end
`else
  logic unused_peak;
  assign unused_peak = rd_peak_i | peak_clr_i | latch_take;

  always_comb begin
    rd_sel_dat = '0;
    rd_sel_sat = 1'b0;
    for (int b = 0; b < NBEAMS; b++) begin
      if (int'(rd_beam_i) == b) begin
        rd_sel_dat = snap[b];
        rd_sel_sat = snap_sat[b];
      end
    end
  end
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ack_o <= 1'b0;
      rd_dat_o <= '0;
      rd_sat_o <= 1'b0;
    end else begin
      rd_ack_o <= rd_stb_i;
      rd_dat_o <= rd_stb_i ? rd_sel_dat : '0;
      rd_sat_o <= rd_stb_i & rd_sel_sat;
    end
  end

endmodule

// File: tb/tb_l1_trigger_scaler_v3.sv
// tb/tb_l1_trigger_scaler_v3.sv - directed and random checks of l1_trigger_scaler_v3 against a gate model
module tb_l1_trigger_scaler_v3;
  localparam int NB   = 3;
  localparam int CB   = 4;
  localparam int PB   = 16;
  localparam int HB   = 4;
  localparam int AB   = 2;
  localparam int CMAX = (1 << CB) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NB-1:0] trig = '0;
  logic [NB-1:0] mask = '0;
  logic [HB-1:0] holdoff = '0;
  logic [PB-1:0] period = 16'd1;
  logic          continuous = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          rd_stb = 1'b0;
  logic [AB-1:0] rd_beam = '0;
  logic          rd_peak = 1'b0;
  logic          peak_clr = 1'b0;
  logic [NB-1:0] trigger_o;
  logic          busy_o;
  logic          done_o;
  logic          rd_ack_o;
  logic [CB-1:0] rd_dat_o;
  logic          rd_sat_o;

  int tests = 0;
  int fails = 0;

  // Reference model: gate position counts clocks into the period, pos == length is the latch clock.
  int          m_hold [NB];
  int          m_acc  [NB];
  int          m_snap [NB];
  int          m_peak [NB];
  bit          m_sat  [NB];
  bit          m_ssat [NB];
  bit [NB-1:0] m_trig;
  bit          m_active, m_done, m_ack, m_rsat;
  int          m_pos, m_rdat;

  always #5 clk = ~clk;

  l1_trigger_scaler_v3 #(
    .NBEAMS(NB), .COUNT_BITS(CB), .PERIOD_BITS(PB), .HOLDOFF_BITS(HB)
  ) dut (
    .clk_i(clk), .rst_i(rst), .trig_i(trig), .mask_i(mask), .holdoff_i(holdoff),
    .period_i(period), .continuous_i(continuous), .start_i(start), .stop_i(stop),
    .trigger_o(trigger_o), .busy_o(busy_o), .done_o(done_o),
    .rd_stb_i(rd_stb), .rd_beam_i(rd_beam), .rd_peak_i(rd_peak), .peak_clr_i(peak_clr),
    .rd_ack_o(rd_ack_o), .rd_dat_o(rd_dat_o), .rd_sat_o(rd_sat_o)
  );

  function automatic int plen();
    return (period == 0) ? 1 : int'(period);
  endfunction

  function automatic bit at_latch();
    return m_active && (m_pos >= plen());
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_tick();
    bit [NB-1:0] q;
    bit latch_now;
    if (rst) begin
      for (int b = 0; b < NB; b++) begin
        m_hold[b] = 0; m_acc[b] = 0; m_snap[b] = 0; m_peak[b] = 0; m_sat[b] = 0; m_ssat[b] = 0;
      end
      m_trig = '0; m_active = 0; m_done = 0; m_ack = 0; m_rsat = 0; m_pos = 0; m_rdat = 0;
      return;
    end
    for (int b = 0; b < NB; b++) q[b] = trig[b] & mask[b] & (m_hold[b] == 0);
    m_ack = rd_stb; m_rdat = 0; m_rsat = 0;
    if (rd_stb && int'(rd_beam) < NB) begin
      m_rdat = m_snap[rd_beam]; m_rsat = m_ssat[rd_beam];
`ifdef L1_SCALER_PEAK_EN
      if (rd_peak) begin m_rdat = m_peak[rd_beam]; m_rsat = 0; end
`endif
    end
    latch_now = at_latch() && !stop && !start;
`ifdef L1_SCALER_PEAK_EN
    for (int b = 0; b < NB; b++) begin
      if (peak_clr) m_peak[b] = 0;
      else if (latch_now && m_acc[b] > m_peak[b]) m_peak[b] = m_acc[b];
    end
`endif
    m_done = 0;
    if (stop) m_active = 0;
    else if (start) begin
      m_active = 1; m_pos = 0;
      for (int b = 0; b < NB; b++) begin m_acc[b] = 0; m_sat[b] = 0; end
    end else if (m_active) begin
      if (m_pos < plen()) begin
        for (int b = 0; b < NB; b++)
          if (q[b]) begin
            if (m_acc[b] == CMAX) m_sat[b] = 1;
            else m_acc[b]++;
          end
        m_pos++;
      end else begin
        m_done = 1;
        for (int b = 0; b < NB; b++) begin m_snap[b] = m_acc[b]; m_ssat[b] = m_sat[b]; end
        if (continuous) begin
          m_pos = 0;
          for (int b = 0; b < NB; b++) begin m_acc[b] = int'(q[b]); m_sat[b] = 0; end
        end else m_active = 0;
      end
    end
    for (int b = 0; b < NB; b++)
      m_hold[b] = q[b] ? int'(holdoff) : ((m_hold[b] > 0) ? m_hold[b] - 1 : 0);
    m_trig = q;
    if (latch_now) begin end
  endtask

  task automatic step();
    model_tick();
    @(posedge clk);
    #1;
    chk("trigger", trigger_o, m_trig);
    chk("busy", busy_o, m_active);
    chk("done", done_o, m_done);
    chk("rd_ack", rd_ack_o, m_ack);
    chk("rd_dat", rd_dat_o, m_rdat);
    chk("rd_sat", rd_sat_o, m_rsat);
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic run_to_done(input string tag, input int budget);
    int n = 0;
    do begin step(); n++; end while (done_o !== 1'b1 && n < budget);
    chk(tag, done_o, 1);
  endtask

  task automatic wait_latch(input string tag, input int budget);
    int n = 0;
    while (!at_latch() && n < budget) begin step(); n++; end
    chk(tag, at_latch(), 1);
  endtask

  task automatic rd(input int beam, input logic [63:0] exp_dat, input logic exp_sat, input string tag);
    rd_beam = AB'(beam); rd_stb = 1'b1; step(); rd_stb = 1'b0;
    chk({tag, "_ack"}, rd_ack_o, 1);
    chk(tag, rd_dat_o, exp_dat);
    chk({tag, "_sat"}, rd_sat_o, exp_sat);
  endtask

  initial begin
    int tcnt, dcnt;
    rst = 1'b1;
    step(); step();
    chk("reset_busy", busy_o, 0);
    chk("reset_trig", trigger_o, 0);
    rst = 1'b0;
    mask = '1;

    // Saturation: 40 qualified clocks into a 4-bit counter, then an empty period.
    period = 16'd40; holdoff = '0; trig = '1;
    pulse_start();
    run_to_done("t3_done", 60);
    rd(0, 15, 1'b1, "t3_snap");
    trig = '0;
    pulse_start();
    run_to_done("t3b_done", 60);
    rd(0, 0, 1'b0, "t3_clear");

    // Holdoff 3 on a constant trigger: one qualified trigger every 4th clock.
    period = 16'd10; holdoff = 4'd3;
    pulse_start();
    trig = 3'b001;
    tcnt = 0; dcnt = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (i < 11) tcnt += int'(trigger_o[0]);
      dcnt += int'(done_o);
    end
    trig = '0;
    chk("t1_trig_count", tcnt, 3);
    chk("t1_done_count", dcnt, 1);
    chk("t1_busy_after", busy_o, 0);
    rd(0, 3, 1'b0, "t1_snap");

    // Masked beam and a mid-gate stop.
    mask = 3'b110; trig = '1; holdoff = '0; period = 16'd20;
    pulse_start();
    for (int i = 0; i < 5; i++) begin step(); chk("t4_trig0", trigger_o[0], 0); end
    stop = 1'b1; step(); stop = 1'b0;
    chk("t4_busy", busy_o, 0);
    dcnt = 0;
    for (int i = 0; i < 25; i++) begin step(); dcnt += int'(done_o); end
    chk("t4_no_done", dcnt, 0);
    rd(0, 3, 1'b0, "t4_snap_kept");
    mask = '1; trig = '0;

    // Continuous gate: a pulse in the latch clock belongs to the next period.
    continuous = 1'b1; period = 16'd8;
    pulse_start();
    wait_latch("t2_latch", 20);
    trig = 3'b010; step(); trig = '0;
    rd(1, 0, 1'b0, "t2_first");
    run_to_done("t2_done", 20);
    rd(1, 1, 1'b0, "t2_second");
    continuous = 1'b0;
    stop = 1'b1; step(); stop = 1'b0;

    // Read during latch, out-of-range beam, reset mid-count.
    period = 16'd6; trig = 3'b001;
    pulse_start();
    wait_latch("t5_latch", 20);
    rd(0, 0, 1'b0, "t5_latch_old");
    trig = '0;
    rd(0, 6, 1'b0, "t5_new");
    rd(3, 0, 1'b0, "t5_oob");
    trig = '1;
    pulse_start();
    step(); step(); step();
    rst = 1'b1; step(); rst = 1'b0;
    chk("t5_rst_busy", busy_o, 0);
    chk("t5_rst_trig", trigger_o, 0);
    trig = '0;
    rd(0, 0, 1'b0, "t5_rst_snap");

`ifdef L1_SCALER_PEAK_EN
    trig = 3'b001; holdoff = '0;
    period = 16'd5; pulse_start(); run_to_done("t6_p5", 20);
    period = 16'd9; pulse_start(); run_to_done("t6_p9", 20);
    period = 16'd2; pulse_start(); run_to_done("t6_p2", 20);
    trig = '0; rd_peak = 1'b1;
    rd(0, 9, 1'b0, "t6_peak");
    rd_peak = 1'b0;
    trig = 3'b001; period = 16'd4; pulse_start();
    wait_latch("t6_latch", 20);
    peak_clr = 1'b1; step(); peak_clr = 1'b0; trig = '0;
    rd_peak = 1'b1;
    rd(0, 0, 1'b0, "t6_peak_clr");
    rd_peak = 1'b0;
`endif

    for (int i = 0; i < 1500; i++) begin
      trig = NB'($urandom);
      mask = ($urandom_range(0, 3) == 0) ? NB'($urandom) : '1;
      if ($urandom_range(0, 15) == 0) holdoff = HB'($urandom_range(0, 3));
      if ($urandom_range(0, 31) == 0) continuous = 1'($urandom);
      if (!m_active) period = PB'($urandom_range(0, 12));
      start    = ($urandom_range(0, 39) == 0);
      stop     = ($urandom_range(0, 79) == 0);
      rd_stb   = 1'($urandom);
      rd_beam  = AB'($urandom);
      rd_peak  = 1'($urandom);
      peak_clr = ($urandom_range(0, 99) == 0);
      rst      = ($urandom_range(0, 499) == 0);
      step();
    end
    start = 1'b0; stop = 1'b0; rd_stb = 1'b0; peak_clr = 1'b0; rst = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
